// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-N lane striper/gatherer.
package demux_pkg;

    // Default data word width in bits.
    localparam int DEF_WIDTH = 8;

    // Default output lane count. Must be a power of two.
    localparam int DEF_LANES = 2;

    // Per-group operating mode.
    // STRIPE: each word goes straight out on its own lane.
    // GATHER: words are collected, then emitted together as one group.
    typedef enum logic {
        STRIPE = 1'b0,
        GATHER = 1'b1
    } mode_e;

endpackage

// File: rtl/demux_lane_ctr.sv
// Lane pointer for the striper. It counts accepted words modulo LANES and
// returns to lane 0 on a flush. Reset has priority over everything else.
module demux_lane_ctr #(
    parameter int LANES = 2,
    parameter int PTR_W = $clog2(LANES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [PTR_W-1:0] ptr_o
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(LANES - 1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Next pointer value.
    // A flush overrides a same-cycle increment, so the next group starts at lane 0.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    // Pointer register, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/demux_1xn_striper.sv
// 1-to-N word demux.
// STRIPE mode: each word lands on lane lane_ptr one cycle later.
// GATHER mode: words are collected into a buffer and released together, either
// when the group is full or when a flush arrives.
// The mode is sampled only at the start of a group (lane_ptr == 0), so a group
// never changes mode partway through.
module demux_1xn_striper
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   valid_in,
    input  logic                   mode,
    input  logic                   flush,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [LANES-1:0]       valid_out,
    output logic                   busy
);

    localparam int               PTR_W = $clog2(LANES);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(LANES - 1);

    logic [PTR_W-1:0] lane_ptr;
    logic             ptr_zero;
    mode_e            mode_q;
    mode_e            eff_mode;
    logic             is_gather;
    logic             grp_emit;

    // Lanes already written in the current group (strictly below lane_ptr).
    logic [LANES-1:0] below_ptr;

    demux_lane_ctr #(
        .LANES (LANES),
        .PTR_W (PTR_W)
    ) u_lane_ctr (
        .clk   (clk),
        .reset (reset),
        .inc_i (valid_in),
        .clr_i (flush),
        .ptr_o (lane_ptr)
    );

    assign ptr_zero  = (lane_ptr == '0);
    assign busy      = !ptr_zero;
    assign eff_mode  = ptr_zero ? mode_e'(mode) : mode_q;
    assign is_gather = (eff_mode == GATHER);

    // A gathered group is emitted in two cases:
    //  - the word for the last lane arrives (the group is complete), or
    //  - a flush arrives while the group holds at least one word, counting
    //    any word that arrives in the same cycle.
    assign grp_emit = is_gather &&
                      ((valid_in && (lane_ptr == LAST)) ||
                       (flush && (!ptr_zero || valid_in)));

    // Thermometer mask of lanes filled before the current word.
    always_comb begin
        below_ptr = '0;
        for (int i = 0; i < LANES; i++) begin
            below_ptr[i] = (i < int'(lane_ptr));
        end
    end

    // Latch the mode at the start of each group. It holds until lane_ptr
    // returns to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= STRIPE;
        end else if (ptr_zero) begin
            mode_q <= mode_e'(mode);
        end
    end

    // Per-lane datapath: gather buffer, output data register and output valid.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam logic [PTR_W-1:0] K = PTR_W'(k);

        logic             hit;
        logic             filled;
        logic [WIDTH-1:0] buf_q;
        logic [WIDTH-1:0] buf_d;
        logic [WIDTH-1:0] dout_q;
        logic [WIDTH-1:0] dout_d;
        logic             vout_q;
        logic             vout_d;

        assign hit    = valid_in && (lane_ptr == K);
        assign filled = below_ptr[k] || hit;

        // Next state for this lane.
        // On an emission, lanes with no word go out as 0 and the buffer clears.
        // In STRIPE mode, lanes that are not written keep their data but drop
        // their valid bit.
        always_comb begin
            buf_d  = buf_q;
            dout_d = dout_q;
            vout_d = 1'b0;
            if (grp_emit) begin
                buf_d  = '0;
                dout_d = filled ? (hit ? data_in : buf_q) : '0;
                vout_d = filled;
            end else if (is_gather) begin
                if (hit) begin
                    buf_d = data_in;
                end
            end else if (hit) begin
                dout_d = data_in;
                vout_d = 1'b1;
            end
        end

        // Lane registers. Reset clears them and drops any partial group.
        always_ff @(posedge clk) begin
            if (reset) begin
                buf_q  <= '0;
                dout_q <= '0;
                vout_q <= 1'b0;
            end else begin
                buf_q  <= buf_d;
                dout_q <= dout_d;
                vout_q <= vout_d;
            end
        end

        assign data_out[k*WIDTH +: WIDTH] = dout_q;
        assign valid_out[k]               = vout_q;
    end

endmodule

// File: tb/tb_demux_1xn_striper.sv
// Self-checking bench for demux_1xn_striper.
// Two instances (LANES=2 and LANES=4) see the same stimulus. A behavioural
// model predicts each instance's output. The prediction is queued when the
// stimulus is driven, then popped and compared after the clock edge.
module tb_demux_1xn_striper;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        mode;
    logic        flush;
    logic [15:0] dout2;
    logic [1:0]  vout2;
    logic        busy2;
    logic [31:0] dout4;
    logic [3:0]  vout4;
    logic        busy4;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  v;
        logic        b;
    } exp_t;

    exp_t q2[$];
    exp_t q4[$];

    // Model state: index 0 tracks the LANES=2 instance, index 1 the LANES=4 one.
    logic [7:0] mbuf[2][8];
    logic [7:0] mout[2][8];
    logic [7:0] mvld[2];
    int         mptr[2];
    logic       mmq[2];

    always #5 clk = ~clk;

    demux_1xn_striper #(.WIDTH(8), .LANES(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .mode      (mode),
        .flush     (flush),
        .data_out  (dout2),
        .valid_out (vout2),
        .busy      (busy2)
    );

    demux_1xn_striper #(.WIDTH(8), .LANES(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .mode      (mode),
        .flush     (flush),
        .data_out  (dout4),
        .valid_out (vout4),
        .busy      (busy4)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance model n (with L lanes) by one clock edge and return the
    // outputs expected after that edge.
    task automatic model(input int n, input int L, input logic [7:0] d,
                         input logic v, input logic m, input logic fl,
                         input logic rst, output exp_t e);
        logic em;
        int   cnt;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                mbuf[n][i] = 8'h00;
                mout[n][i] = 8'h00;
            end
            mvld[n] = 8'h00;
            mptr[n] = 0;
            mmq[n]  = 1'b0;
        end else begin
            em = (mptr[n] == 0) ? m : mmq[n];
            if (mptr[n] == 0) mmq[n] = m;
            mvld[n] = 8'h00;
            if (!em) begin
                if (v) begin
                    mout[n][mptr[n]] = d;
                    mvld[n][mptr[n]] = 1'b1;
                    mptr[n] = (mptr[n] + 1) % L;
                end
                if (fl) mptr[n] = 0;
            end else begin
                if (v) mbuf[n][mptr[n]] = d;
                cnt = v ? mptr[n] + 1 : mptr[n];
                if (cnt == L || (fl && cnt > 0)) begin
                    for (int i = 0; i < L; i++) begin
                        mout[n][i] = (i < cnt) ? mbuf[n][i] : 8'h00;
                        mvld[n][i] = (i < cnt);
                        mbuf[n][i] = 8'h00;
                    end
                    mptr[n] = 0;
                end else begin
                    mptr[n] = cnt;
                end
            end
        end
        e.d = '0;
        for (int i = 0; i < L; i++) e.d[i*8 +: 8] = mout[n][i];
        e.v = mvld[n];
        e.b = (mptr[n] != 0);
    endtask

    // Drive one cycle of stimulus, queue the predictions, then compare after
    // the edge.
    task automatic drv(input logic [7:0] d, input logic v, input logic m,
                       input logic fl, input logic rst);
        exp_t e;
        data_in  = d;
        valid_in = v;
        mode     = m;
        flush    = fl;
        reset    = rst;
        model(0, 2, d, v, m, fl, rst, e);
        q2.push_back(e);
        model(1, 4, d, v, m, fl, rst, e);
        q4.push_back(e);
        @(posedge clk);
        #1;
        e = q2.pop_front();
        chk("l2_data", {48'd0, dout2}, e.d);
        chk("l2_valid", {56'd0, 6'd0, vout2}, {56'd0, e.v});
        chk("l2_busy", {63'd0, busy2}, {63'd0, e.b});
        e = q4.pop_front();
        chk("l4_data", {32'd0, dout4}, e.d);
        chk("l4_valid", {56'd0, 4'd0, vout4}, {56'd0, e.v});
        chk("l4_busy", {63'd0, busy4}, {63'd0, e.b});
    endtask

    initial begin
        reset = 1'b1; data_in = '0; valid_in = 1'b0; mode = 1'b0; flush = 1'b0;
        @(negedge clk);

        // Reset state
        drv(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        drv(8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_vout4", {60'd0, vout4}, 64'd0);
        chk("rst_dout4", {32'd0, dout4}, 64'd0);

        // STRIPE, LANES=2: A1, B2, C3
        drv(8'hA1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s_v0", {62'd0, vout2}, 64'h1);
        chk("s_l0", {56'd0, dout2[7:0]}, 64'hA1);
        drv(8'hB2, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s_v1", {62'd0, vout2}, 64'h2);
        chk("s_l1", {56'd0, dout2[15:8]}, 64'hB2);
        drv(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s_v2", {62'd0, vout2}, 64'h1);
        chk("s_l0b", {48'd0, dout2}, 64'hB2C3);

        // Flush in STRIPE mode only resets the pointer.
        drv(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sflush_busy", {62'd0, busy2, busy4}, 64'd0);

        // GATHER full group, LANES=4
        drv(8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
        drv(8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
        drv(8'h33, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("g_pre", {60'd0, vout4}, 64'd0);
        drv(8'h44, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("g_data", {32'd0, dout4}, 64'h44332211);
        chk("g_vld", {60'd0, vout4}, 64'hF);
        drv(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("g_after", {60'd0, vout4}, 64'd0);

        // GATHER partial group, then a flush on its own
        drv(8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
        drv(8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("gf_busy", {63'd0, busy4}, 64'd1);
        drv(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("gf_data", {32'd0, dout4}, 64'h00002211);
        chk("gf_vld", {60'd0, vout4}, 64'h3);
        chk("gf_busy0", {63'd0, busy4}, 64'd0);

        // Flush together with a word at lane_ptr=2
        drv(8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
        drv(8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
        drv(8'h55, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("gfv_data", {32'd0, dout4}, 64'h00552211);
        chk("gfv_vld", {60'd0, vout4}, 64'h7);

        // Mode change mid-group is ignored until the next group
        drv(8'h66, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("mt_v", {62'd0, vout2}, 64'h2);
        chk("mt_l1", {56'd0, dout2[15:8]}, 64'h77);
        drv(8'h88, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("mt_gpend", {62'd0, vout2}, 64'd0);
        drv(8'h99, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("mt_gdata", {48'd0, dout2}, 64'h9988);
        chk("mt_gvld", {62'd0, vout2}, 64'h3);
        drv(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset mid-group drops the partial group
        drv(8'hA1, 1'b1, 1'b1, 1'b0, 1'b0);
        drv(8'hA2, 1'b1, 1'b1, 1'b0, 1'b0);
        drv(8'hA3, 1'b1, 1'b1, 1'b0, 1'b0);
        drv(8'hA4, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rm_vld", {60'd0, vout4}, 64'd0);
        chk("rm_busy", {63'd0, busy4}, 64'd0);
        drv(8'hB1, 1'b1, 1'b1, 1'b0, 1'b0);
        drv(8'hB2, 1'b1, 1'b1, 1'b0, 1'b0);
        drv(8'hB3, 1'b1, 1'b1, 1'b0, 1'b0);
        drv(8'hB4, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rm_data", {32'd0, dout4}, 64'hB4B3B2B1);
        chk("rm_vld2", {60'd0, vout4}, 64'hF);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drv(8'($urandom), ($urandom_range(0, 9) < 7), 1'($urandom),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_1xn_striper.md
DEMUX_1XN_STRIPER -- requirements
Module: demux_1xn_striper

Interface
REQ-001 Parameter WIDTH, default 8: bits per data word; legal range 1..64.
REQ-002 Parameter LANES, default 2: output lane count; power of two, 2..8.
REQ-003 Port clk, input, 1 bit: single clock; every register updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port data_in, input, WIDTH bits: input word.
REQ-006 Port valid_in, input, 1 bit: data_in is accepted this cycle; there is no backpressure.
REQ-007 Port mode, input, 1 bit: 0 = STRIPE, 1 = GATHER.
REQ-008 Port flush, input, 1 bit: in GATHER mode, emit the partial group.
REQ-009 Port data_out, output, LANES*WIDTH bits: lane k occupies bits [k*WIDTH +: WIDTH].
REQ-010 Port valid_out, output, LANES bits: bit k qualifies lane k for one cycle.
REQ-011 Port busy, output, 1 bit: high when lane_ptr != 0.

Function
REQ-012 Internal lane_ptr is log2(LANES) bits; it SHALL increment on each accepted valid_in and wrap from LANES-1 to 0.
REQ-013 Effective mode: when lane_ptr == 0, the current word SHALL use the mode input and mode_q SHALL load mode; when lane_ptr != 0, mode_q SHALL govern and the mode input SHALL be ignored.
REQ-014 STRIPE, valid_in with lane_ptr = k: next cycle, lane k of data_out SHALL equal data_in and valid_out SHALL be one-hot at bit k; latency is 1 cycle.
REQ-015 STRIPE: lanes not written SHALL hold their previous data, with their valid_out bits at 0.
REQ-016 GATHER, valid_in with lane_ptr = k < LANES-1: the word SHALL be stored in buffer lane k; valid_out SHALL be 0 next cycle.
REQ-017 GATHER, valid_in with lane_ptr = LANES-1: next cycle, data_out SHALL equal the buffer with the current word in lane LANES-1, and valid_out SHALL be all ones for one cycle.
REQ-018 GATHER flush with lane_ptr > 0 or valid_in: next cycle, filled lanes SHALL be emitted with their valid_out bits set; unfilled lanes SHALL be 0 with valid_out bits 0; lane_ptr SHALL return to 0.
REQ-019 flush together with valid_in: the current word SHALL be included in the flushed group.
REQ-020 flush with lane_ptr == 0 and no valid_in: no output; no state change.
REQ-021 flush in STRIPE mode: lane_ptr SHALL return to 0 (after any simultaneous word is written); no other effect.
REQ-022 valid_in low: lane_ptr SHALL hold; valid_out SHALL be 0 next cycle unless a flush emits.
REQ-023 After a GATHER emission, the buffer SHALL clear to 0.

Reset
REQ-024 While reset is high: data_out = 0, valid_out = 0, busy = 0, lane_ptr = 0, buffer = 0, mode_q = STRIPE.
REQ-025 Reset SHALL override valid_in and flush in the same cycle.
REQ-026 Reset mid-group SHALL discard the partial group without emitting it.

Structure
REQ-027 Shared package demux_pkg SHALL hold default WIDTH and LANES and the mode enum (STRIPE = 0, GATHER = 1).
REQ-028 Sub-module demux_lane_ctr SHALL implement lane_ptr: increment, wrap and clear (on flush or reset).
REQ-029 The datapath (buffer, output registers) SHALL be in the top level, built from generate loops over LANES.

Verification
REQ-030 STRIPE, LANES=2, words 0xA1, 0xB2, 0xC3 on consecutive cycles -> valid_out 01, 10, 01; lane0 = 0xA1, then 0xC3; lane1 = 0xB2.
REQ-031 GATHER, LANES=4, words 0x11, 0x22, 0x33, 0x44 -> one cycle after 0x44: data_out = 0x44332211, valid_out = 1111; 0000 in the prior cycles.
REQ-032 GATHER, LANES=4, words 0x11, 0x22, then flush alone -> data_out = 0x00002211, valid_out = 0011; busy drops to 0.
REQ-033 GATHER, LANES=4, word 0x55 with flush at lane_ptr = 2 (after 0x11, 0x22) -> data_out = 0x00552211, valid_out = 0111.
REQ-034 mode toggled 0→1 at lane_ptr = 1 (LANES=2) -> second word is still striped; GATHER takes effect from the next group.
REQ-035 reset asserted after 3 of 4 GATHER words -> no emission; next 4 words produce one clean group.
